cache_refill_unit: RTL and testbench

Miss-handling engine between an L1 cache (instruction or data) and the AXI read-channel merge stage. It accepts one miss request at a time and issues a single AR request: a 16-beat INCR burst for a cached line, or a single beat for an uncached access. It collects the returned beats into a line buffer and pulses completion with the assembled line. One instance serves each cache. Its `ren` output drives that cache's select input on the merge stage.

---
 rtl/cache_refill_unit.sv | 148 ++++++++++++++
 tb/tb_cache_refill_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_unit.sv
// -----------------------------------------------------------------------------
// cache_refill_unit
//
// Miss-handling engine between an L1 cache and the AXI read-channel merge
// stage. Accepts one miss at a time, issues a single AR request, collects the
// returned beats into a line buffer and pulses refill_done with the line.
// A cached miss is a LINE_WORDS-beat INCR burst, and an uncached miss is a
// single word.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. arvalid holds, with araddr stable, until arready. rready is high
// for the whole R phase. miss_ack is high only in IDLE, so a miss is taken on
// any edge with miss_req & miss_ack.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   miss_req/addr/cached     refill request from the cache
//   miss_ack                 request accepted this cycle
//   ren, cache_ena           channel ownership / burst mode to the merge stage
//   araddr, arvalid, arready AR channel
//   rdata, rvalid, rlast,
//   rready                   R channel
//   line_data                assembled line, word i at [32i+31:32i]
//   refill_addr              latched miss address
//   refill_done              one-cycle completion pulse
//   refill_err               rlast arrived at an unexpected beat index
// -----------------------------------------------------------------------------
module cache_refill_unit #(
    parameter int LINE_WORDS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [31:0]             miss_addr,
    input  logic                    miss_cached,
    output logic                    miss_ack,
    output logic                    ren,
    output logic                    cache_ena,
    output logic [31:0]             araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata,
    input  logic                    rvalid,
    input  logic                    rlast,
    output logic                    rready,
    output logic [32*LINE_WORDS-1:0] line_data,
    output logic [31:0]             refill_addr,
    output logic                    refill_done,
    output logic                    refill_err
);

    localparam int OFS = $clog2(LINE_WORDS * 4);
    localparam int CW  = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic            mode_q;
    logic            sat_q;    // a beat has already landed at the saturated index
    logic            accept;
    logic            beat;
    logic [CW-1:0]   wr_idx;
    logic [CW-1:0]   exp_last;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (miss_req)        state_d = S_AR;
            S_AR:    if (arready)         state_d = S_R;
            S_R:     if (rvalid && rlast) state_d = S_DONE;
            S_DONE:                       state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ outputs
    // All outputs decode from registered state only, so refill_done has no
    // combinational path from the R channel.
    assign miss_ack    = (state_q == S_IDLE);
    assign arvalid     = (state_q == S_AR);
    assign rready      = (state_q == S_R);
    assign ren         = (state_q == S_AR) || (state_q == S_R);
    assign refill_done = (state_q == S_DONE);
    assign cache_ena   = (state_q != S_IDLE) && mode_q;
    assign araddr      = (state_q != S_AR) ? 32'h0 :
                         mode_q ? {refill_addr[31:OFS], {OFS{1'b0}}} :
                                  refill_addr;

    assign accept   = (state_q == S_IDLE) && miss_req;
    assign beat     = (state_q == S_R) && rvalid;
    assign wr_idx   = mode_q ? cnt_q : '0;
    assign exp_last = mode_q ? LAST_IDX : '0;

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            sat_q       <= 1'b0;
            refill_addr <= 32'h0;
            line_data   <= '0;
            refill_err  <= 1'b0;
        end else begin
            if (accept) begin
                refill_addr <= miss_addr;
                mode_q      <= miss_cached;
                line_data   <= '0;
                cnt_q       <= '0;
                sat_q       <= 1'b0;
                refill_err  <= 1'b0;
            end
            if (beat) begin
                for (int i = 0; i < LINE_WORDS; i++) begin
                    if (CW'(i) == wr_idx) begin
                        line_data[32*i +: 32] <= rdata;
                    end
                end
                if (cnt_q != LAST_IDX) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    sat_q <= 1'b1;
                end
                // Overrun past the saturated slot, or rlast at the wrong index.
                if (sat_q || (rlast && (cnt_q != exp_last))) begin
                    refill_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_unit.sv
module tb_cache_refill_unit;

    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            miss_req = 1'b0;
    logic [31:0]     miss_addr = 32'h0;
    logic            miss_cached = 1'b0;
    logic            miss_ack;
    logic            ren;
    logic            cache_ena;
    logic [31:0]     araddr;
    logic            arvalid;
    logic            arready = 1'b0;
    logic [31:0]     rdata = 32'h0;
    logic            rvalid = 1'b0;
    logic            rlast = 1'b0;
    logic            rready;
    logic [32*LW-1:0] line_data;
    logic [31:0]     refill_addr;
    logic            refill_done;
    logic            refill_err;

    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    logic [31:0]     exp_q[$];

    cache_refill_unit #(.LINE_WORDS(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .miss_cached (miss_cached),
        .miss_ack    (miss_ack),
        .ren         (ren),
        .cache_ena   (cache_ena),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rlast       (rlast),
        .rready      (rready),
        .line_data   (line_data),
        .refill_addr (refill_addr),
        .refill_done (refill_done),
        .refill_err  (refill_err)
    );

    // ------------------------------------------------ clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ":miss_ack"},    miss_ack, 1);
        chk({tag, ":ren"},         ren, 0);
        chk({tag, ":cache_ena"},   cache_ena, 0);
        chk({tag, ":arvalid"},     arvalid, 0);
        chk({tag, ":rready"},      rready, 0);
        chk({tag, ":refill_done"}, refill_done, 0);
        chk({tag, ":refill_err"},  refill_err, 0);
        chk({tag, ":araddr"},      araddr, 0);
        chk({tag, ":refill_addr"}, refill_addr, 0);
        chk({tag, ":line_zero"},   32'(line_data != '0), 0);
    endtask

    // Reference model: the line is what the beats leave behind. Cached beat k
    // lands in word min(k, LW-1); every uncached beat lands in word 0. A
    // transaction is clean only with exactly LW (cached) or 1 (uncached) beats.
    task automatic check_line(input string tag, input logic cached,
                              input logic [31:0] beats[$]);
        for (int w = 0; w < LW; w++) begin
            logic [31:0] e;
            e = 32'h0;
            for (int k = 0; k < beats.size(); k++) begin
                int idx;
                idx = cached ? ((k < LW) ? k : LW - 1) : 0;
                if (idx == w) e = beats[k];
            end
            exp_q.push_back(e);
        end
        for (int w = 0; w < LW; w++) begin
            chk($sformatf("%s:word%0d", tag, w), line_data[32*w +: 32], exp_q.pop_front());
        end
        chk({tag, ":refill_err"}, refill_err,
            32'(cached ? (beats.size() != LW) : (beats.size() != 1)));
    endtask

    task automatic run_txn(input string tag, input logic [31:0] addr, input logic cached,
                           input int ar_delay, input int n_beats, input logic gap,
                           input logic fixed, input logic [31:0] base, input logic hold);
        logic [31:0] beats[$];
        logic [31:0] exp_ar;
        logic [31:0] d;
        int a;
        int waitc;
        waitc = 0;
        while (!miss_ack && waitc < 100) begin
            tick();
            waitc++;
        end
        chk({tag, ":idle_ack"}, miss_ack, 1);
        if (hold) chk({tag, ":b2b_no_wait"}, waitc, 0);
        exp_ar = cached ? (addr & ~32'(LW * 4 - 1)) : addr;
        miss_req    = 1'b1;
        miss_addr   = addr;
        miss_cached = cached;
        a = cyc;
        tick();
        if (!hold) miss_req = 1'b0;
        // AR phase: stray R-channel traffic must be ignored here.
        for (int i = 0; i <= ar_delay; i++) begin
            rvalid  = 1'b1;
            rdata   = $urandom;
            rlast   = 1'($urandom_range(0, 1));
            arready = (i == ar_delay);
            chk({tag, ":arvalid"},   arvalid, 1);
            chk({tag, ":araddr"},    araddr, exp_ar);
            chk({tag, ":ar_ena"},    cache_ena, 32'(cached));
            chk({tag, ":ar_ren"},    ren, 1);
            chk({tag, ":ar_rready"}, rready, 0);
            chk({tag, ":ar_ack"},    miss_ack, 0);
            tick();
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        for (int k = 0; k < n_beats; k++) begin
            if (gap && k > 0) begin
                rvalid = 1'b0;
                chk({tag, ":gap_rready"}, rready, 1);
                tick();
            end
            d = fixed ? base + 32'(k) : $urandom;
            beats.push_back(d);
            rvalid = 1'b1;
            rdata  = d;
            rlast  = (k == n_beats - 1);
            chk({tag, ":r_rready"}, rready, 1);
            chk({tag, ":r_done"},   refill_done, 0);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk({tag, ":done"},     refill_done, 1);
        chk({tag, ":latency"},  cyc - a, 2 + ar_delay + n_beats + (gap ? n_beats - 1 : 0));
        chk({tag, ":done_ena"}, cache_ena, 32'(cached));
        tick();
        chk({tag, ":done_pulse"}, refill_done, 0);
        chk({tag, ":back_idle"},  miss_ack, 1);
        chk({tag, ":idle_ren"},   ren, 0);
        chk({tag, ":idle_ena"},   cache_ena, 0);
        chk({tag, ":refill_addr"}, refill_addr, addr);
        check_line(tag, cached, beats);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk_reset_state("reset");

        run_txn("cached", 32'h1FC0_0124, 1'b1, 0, 16, 1'b0, 1'b1, 32'hA0, 1'b0);
        run_txn("uncached", 32'hBFAF_F004, 1'b0, 5, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        run_txn("gaps", 32'h1FC0_0124, 1'b1, 0, 16, 1'b1, 1'b1, 32'hA0, 1'b0);
        run_txn("short", 32'h0000_2040, 1'b1, 0, 8, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn("overrun", 32'h0000_3000, 1'b1, 1, 17, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn("unc_two", 32'h0000_4008, 1'b0, 0, 2, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset during beat 5 of a cached burst.
        miss_req = 1'b1;
        miss_addr = 32'h8000_0040;
        miss_cached = 1'b1;
        tick();
        miss_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1;
            rdata = $urandom;
            tick();
        end
        rdata = $urandom;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rvalid = 1'b0;
        chk_reset_state("mid_reset");
        run_txn("post_reset", 32'h9000_0010, 1'b0, 0, 1, 1'b0, 1'b0, 32'h0, 1'b0);

        // miss_req held high with alternating mode.
        for (int t = 0; t < 4; t++) begin
            logic c;
            c = (t % 2 == 0);
            run_txn($sformatf("b2b%0d", t), $urandom, c, 0, c ? 16 : 1, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        miss_req = 1'b0;

        // Randomised transactions.
        for (int t = 0; t < 6; t++) begin
            logic c;
            int n;
            int sel;
            c = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            if (c) n = (sel < 2) ? 16 : (sel == 2) ? 17 : $urandom_range(1, 15);
            else   n = (sel < 3) ? 1 : 2;
            run_txn($sformatf("rand%0d", t), $urandom, c, $urandom_range(0, 3), n,
                    1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
        end

        // ------------------------------------------------------- report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
